spike_threshold_unit: RTL

- Stage directly downstream of the per-neuron potential decay stage. It consumes the decayed IEEE-754 single-precision membrane potential for one time-multiplexed neuron at a time.
- Compares the potential against a firing threshold and emits a spike. On a spike, the stored potential is replaced by a reset potential.
- Enforces a per-neuron refractory period counted in timesteps.
- The potential it outputs is written back to neuron state and feeds the next decay pass.

---
 rtl/spike_threshold_unit_if.sv | 28 ++
 rtl/spike_threshold_unit.sv | 126 ++++++++++++
 2 files changed

// File: rtl/spike_threshold_unit_if.sv
// spike_threshold_unit_if: input and output streams of the spike threshold stage
//   in_valid/in_ready/in_addr/in_potential : decayed potential from the decay stage
//   out_valid/out_ready/out_addr/out_potential/spike : write-back result and spike flag
//   master : environment side (drives inputs, accepts results)
//   slave  : the threshold stage itself
interface spike_threshold_unit_if #(
    parameter int ADDR_W = 12
) ();
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_addr;
    logic [31:0]       in_potential;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [31:0]       out_potential;
    logic              spike;

    modport master (
        output in_valid, in_addr, in_potential, out_ready,
        input  in_ready, out_valid, out_addr, out_potential, spike
    );

    modport slave (
        input  in_valid, in_addr, in_potential, out_ready,
        output in_ready, out_valid, out_addr, out_potential, spike
    );
endinterface

// File: rtl/spike_threshold_unit.sv
// spike_threshold_unit: FP32 threshold compare, spike generation and per-neuron refractory tracking
//   CLK               : system clock, rising edge
//   rst_n             : asynchronous active-low reset
//   threshold_i       : FP32 firing threshold (quasi-static)
//   reset_potential_i : FP32 potential loaded on spike or while refractory
//   timestep_tick_i   : one-cycle end-of-timestep pulse, decrements refractory counters
//   bus               : slave side of spike_threshold_unit_if (input/output streams)
//   addr_err_o        : sticky flag, an out-of-range neuron address was accepted
//   count_clear_i / spike_count_o : only with SPIKE_COUNT_EN defined; saturating count of
//                       spiking output transfers with synchronous clear
module spike_threshold_unit #(
    parameter int NUM_NEURONS   = 30,
    parameter int ADDR_W        = 12,
    parameter int REFRACT_STEPS = 2,
    parameter int CNT_W         = 4
) (
    input  logic        CLK,
    input  logic        rst_n,
    input  logic [31:0] threshold_i,
    input  logic [31:0] reset_potential_i,
    input  logic        timestep_tick_i,
    spike_threshold_unit_if.slave bus,
`ifdef SPIKE_COUNT_EN
    input  logic        count_clear_i,
    output logic [15:0] spike_count_o,
`endif
    output logic        addr_err_o
);
    logic [CNT_W-1:0]  ref_q [NUM_NEURONS];
    logic [CNT_W-1:0]  ref_d [NUM_NEURONS];
    logic              out_valid_q, out_valid_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic [31:0]       out_pot_q, out_pot_d;
    logic              spike_q, spike_d;
    logic              addr_err_q, addr_err_d;
    logic              take, addr_ok, fire, refractory, spike_now, load;
    logic [CNT_W-1:0]  cur_ref;

    // IEEE-754 a >= b; NaN never satisfies, signed zeros compare equal
    function automatic logic fp_ge(input logic [31:0] a, input logic [31:0] b);
        logic a_nan, b_nan;
        a_nan = (a[30:23] == 8'hFF) && (a[22:0] != '0);
        b_nan = (b[30:23] == 8'hFF) && (b[22:0] != '0);
        if (a_nan || b_nan)
            return 1'b0;
        if (a[30:0] == '0 && b[30:0] == '0)
            return 1'b1;
        if (a[31] != b[31])
            return !a[31];
        return a[31] ? (a[30:0] <= b[30:0]) : (a[30:0] >= b[30:0]);
    endfunction

    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign take         = bus.in_valid && bus.in_ready;
    assign addr_ok      = bus.in_addr < ADDR_W'(NUM_NEURONS);
    assign fire         = fp_ge(bus.in_potential, threshold_i);

    // Mux out the addressed counter without indexing past the array
    always_comb begin
        cur_ref = '0;
        for (int i = 0; i < NUM_NEURONS; i++)
            if (bus.in_addr == ADDR_W'(i))
                cur_ref = ref_q[i];
    end

    assign refractory = addr_ok && (cur_ref != '0);
    assign spike_now  = addr_ok && !refractory && fire;
    assign load       = take && spike_now;

    // A spike load on the same neuron overrides that cycle's tick decrement
    always_comb begin
        for (int i = 0; i < NUM_NEURONS; i++)
            ref_d[i] = (load && bus.in_addr == ADDR_W'(i)) ? CNT_W'(REFRACT_STEPS) :
                       (timestep_tick_i && ref_q[i] != '0) ? ref_q[i] - CNT_W'(1) : ref_q[i];
    end

    always_comb begin
        out_valid_d = take ? 1'b1 : (bus.out_ready ? 1'b0 : out_valid_q);
        out_addr_d  = take ? bus.in_addr : out_addr_q;
        out_pot_d   = !take ? out_pot_q :
                      (refractory || spike_now) ? reset_potential_i : bus.in_potential;
        spike_d     = take ? spike_now : spike_q;
        addr_err_d  = addr_err_q || (take && !addr_ok);
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            ref_q       <= '{default: '0};
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_pot_q   <= '0;
            spike_q     <= 1'b0;
            addr_err_q  <= 1'b0;
        end else begin
            ref_q       <= ref_d;
            out_valid_q <= out_valid_d;
            out_addr_q  <= out_addr_d;
            out_pot_q   <= out_pot_d;
            spike_q     <= spike_d;
            addr_err_q  <= addr_err_d;
        end
    end

    assign bus.out_valid     = out_valid_q;
    assign bus.out_addr      = out_addr_q;
    assign bus.out_potential = out_pot_q;
    assign bus.spike         = spike_q;
    assign addr_err_o        = addr_err_q;

`ifdef SPIKE_COUNT_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb
        cnt_d = count_clear_i ? '0 :
                (bus.out_valid && bus.out_ready && bus.spike && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign spike_count_o = cnt_q;
`endif
endmodule
